up_down_counter_checker: RTL and testbench
==========================================

// Module: up_down_counter_checker
// PURPOSE
//  Passive monitor at the output end of up_down_counter. Samples the counter value and the
//  up_down control each clk, predicts the next value (mod 2^N), and flags every deviation.
//  Sits beside the counter in simulation or on silicon; it drives nothing back into the counter.
// PARAMETERS
//  N         5   counter width; must match the monitored up_down_counter
//  LOCK_CNT  4   consecutive matching samples before locked asserts (1..15)
//  ERR_W     8   width of the saturating error counter
// PORTS
//  clk        in   1      single clock, same as the counter's
//  rst        in   1      synchronous, active-high reset; normally the counter's rst
//  up_down    in   1      direction applied to the counter this cycle (1 = up, 0 = down)
//  cnt_in     in   N      counter output (out) as seen this cycle
//  exp_val    out  N      predicted cnt_in for the next cycle
//  locked     out  1      LOCK_CNT consecutive matches observed since the last sync or mismatch
//  err        out  1      one-cycle pulse: the last sampled cnt_in != exp_val
//  err_count  out  ERR_W  number of mismatches, saturating at 2^ERR_W-1
//  err_val    out  N      cnt_in captured at the most recent mismatch
// BEHAVIOUR
//  - Reset: state=IDLE, exp_val=0, locked=0, err=0, err_count=0, err_val=0, match_run=0.
//  - Counter model: cnt(t+1) = cnt(t)+1 if up_down(t), else cnt(t)-1, mod 2^N. The checker
//    samples up_down and cnt_in on the same edge.
//  - FSM, evaluated each posedge clk with rst low:
//    IDLE  -> SYNC unconditionally. No compare happens in the first cycle after rst falls.
//    SYNC  -> exp_val <= cnt_in +/- 1 per up_down; match_run <= 0; go to TRACK. No compare.
//    TRACK -> compare cnt_in with exp_val.
//      match:    exp_val <= cnt_in +/- 1; match_run++ (saturating at LOCK_CNT);
//                locked <= (match_run+1 >= LOCK_CNT).
//      mismatch: err <= 1 for one cycle; err_count++ (sat); err_val <= cnt_in; locked <= 0;
//                match_run <= 0; next state per UDC_CHK_STICKY_EN.
//    FAULT -> hold; no compares; err=0; exp_val, err_val and err_count frozen. Left only by rst.
//  - Timing: all outputs are registered. err rises in the cycle after the bad sample is clocked.
//    locked rises at the edge that clocks the LOCK_CNT-th consecutive match.
//  - Wrap: 2^N-1 up -> 0 and 0 down -> 2^N-1 are legal matches. Arithmetic is N-bit, carry dropped.
//  - Direction change: handled with no special case, because prediction always uses the current
//    up_down. A reversal is not an error.
//  - rst mid-operation: state returns to IDLE next edge and every output clears, including
//    err_count. The counter's own reset to 0 is therefore never reported as a mismatch.
//  - err_count at saturation: stays at max; err still pulses for each new mismatch.
//  - X/Z on cnt_in: treated as a mismatch.
// CONFIGURATION
//  UDC_CHK_STICKY_EN defined:
//    the first mismatch in TRACK moves the FSM to FAULT. err pulses once, err_count ends at 1,
//    err_val holds the offending value until rst.
//  UDC_CHK_STICKY_EN undefined (default):
//    mismatch resyncs. exp_val <= cnt_in +/- 1 and the FSM stays in TRACK. Every later mismatch
//    is counted and locked re-acquires after LOCK_CNT matches. FAULT is unreachable.
// TESTING (N=5, LOCK_CNT=4, ERR_W=8; counter's out wired to cnt_in)
//  1. rst=1 for 10 clks, then rst=0, up_down=1 for 40 clks -> err never pulses; wrap 31->0 passes;
//     locked=1 from the 4th TRACK match onward; err_count=0.
//  2. From count 2, up_down=0 for 5 clks -> 2,1,0,31,30 all match; locked stays 1.
//  3. Force cnt_in=7 for one clk where 12 is expected (default build) -> err pulses 1 clk,
//     err_val=7, err_count=1, locked=0; locked returns 4 matches later.
//  4. Same glitch with UDC_CHK_STICKY_EN defined -> FSM in FAULT; a second glitch leaves
//     err_count=1; rst clears every output.
//  5. Assert rst for 1 clk while count=17 and locked=1 -> next edge all outputs are 0; no err
//     when the counter restarts from 0.
//  6. Drive random cnt_in for 300 clks (default build) -> err_count saturates at 255; err keeps
//     pulsing on each mismatch.

Source files
------------

// File: rtl/up_down_counter_checker.sv
// Passive next-value monitor for up_down_counter: predicts cnt_in each cycle and counts deviations.
// Optional macro UDC_CHK_STICKY_EN: first mismatch latches the FSM in FAULT until rst.
module up_down_counter_checker #(
    parameter int N        = 5,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_down,
    input  logic [N-1:0]     cnt_in,
    output logic [N-1:0]     exp_val,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [N-1:0]     err_val
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        TRACK,
        FAULT
    } state_t;

    localparam logic [3:0]   LOCK_C = 4'(LOCK_CNT);
    localparam logic [N-1:0] ONE    = N'(1);

    state_t             state, state_nxt;
    logic [3:0]         match_run, match_run_nxt;
    logic [N-1:0]       exp_nxt, err_val_nxt, next_val;
    logic               locked_nxt, err_nxt;
    logic [ERR_W-1:0]   err_count_nxt;

    assign next_val = up_down ? (cnt_in + ONE) : (cnt_in - ONE);

    always_comb begin
        state_nxt     = state;
        match_run_nxt = match_run;
        exp_nxt       = exp_val;
        err_val_nxt   = err_val;
        locked_nxt    = locked;
        err_nxt       = 1'b0;
        err_count_nxt = err_count;
        case (state)
            IDLE: state_nxt = SYNC;
            SYNC: begin
                exp_nxt       = next_val;
                match_run_nxt = '0;
                state_nxt     = TRACK;
            end
            TRACK: begin
                // An X/Z on cnt_in makes the equality unknown, which falls into the mismatch branch.
                if (cnt_in == exp_val) begin
                    exp_nxt = next_val;
                    if (match_run < LOCK_C)
                        match_run_nxt = match_run + 4'd1;
                    locked_nxt = ({1'b0, match_run} + 5'd1) >= {1'b0, LOCK_C};
                end else begin
                    err_nxt       = 1'b1;
                    err_val_nxt   = cnt_in;
                    locked_nxt    = 1'b0;
                    match_run_nxt = '0;
                    if (err_count != '1)
                        err_count_nxt = err_count + 1'b1;
`ifdef UDC_CHK_STICKY_EN
                    state_nxt = FAULT;
`else
                    exp_nxt = next_val;
`endif
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            match_run <= '0;
            exp_val   <= '0;
            err_val   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            match_run <= match_run_nxt;
            exp_val   <= exp_nxt;
            err_val   <= err_val_nxt;
            locked    <= locked_nxt;
            err       <= err_nxt;
            err_count <= err_count_nxt;
        end
    end

endmodule

// File: tb/tb_up_down_counter_checker.sv
// Self-checking bench: behavioural counter drives the checker; an integer reference model predicts every output.
module tb_up_down_counter_checker;
    localparam int N    = 5;
    localparam int LOCK = 4;
    localparam int EW   = 8;
    localparam int MOD  = 1 << N;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_down = 1'b0;
    logic [N-1:0]  cnt_in = '0;
    logic [N-1:0]  exp_val, err_val;
    logic          locked, err;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    up_down_counter_checker #(.N(N), .LOCK_CNT(LOCK), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .up_down(up_down), .cnt_in(cnt_in),
        .exp_val(exp_val), .locked(locked), .err(err),
        .err_count(err_count), .err_val(err_val)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset release, predicted value, run of matches, error tally.
    int m_since = 0, m_pred = 0, m_run = 0, m_errs = 0, m_errval = 0;
    bit m_locked = 0, m_err = 0, m_fault = 0;
    int ctr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int wrap_next(input int v, input bit ud);
        return ud ? (v + 1) % MOD : (v + MOD - 1) % MOD;
    endfunction

    task automatic model_step(input bit r, input bit ud, input int c);
        m_err = 0;
        if (r) begin
            m_since = 0; m_pred = 0; m_run = 0; m_errs = 0; m_errval = 0;
            m_locked = 0; m_fault = 0;
        end else if (m_since == 0) begin
            m_since = 1;
        end else if (m_since == 1) begin
            m_since = 2;
            m_pred  = wrap_next(c, ud);
            m_run   = 0;
        end else if (!m_fault) begin
            if (c == m_pred) begin
                m_pred   = wrap_next(c, ud);
                m_run    = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
                m_locked = (m_run >= LOCK);
            end else begin
                m_err    = 1;
                m_errs   = (m_errs < EMAX) ? m_errs + 1 : EMAX;
                m_errval = c;
                m_locked = 0;
                m_run    = 0;
`ifdef UDC_CHK_STICKY_EN
                m_fault  = 1;
`else
                m_pred   = wrap_next(c, ud);
`endif
            end
        end
    endtask

    task automatic cycle(input bit r, input bit ud, input bit glitch, input int gval);
        logic [N-1:0] seen;
        seen = glitch ? gval[N-1:0] : ctr[N-1:0];
        rst = r; up_down = ud; cnt_in = seen;
        @(posedge clk);
        model_step(r, ud, int'(seen));
        ctr = r ? 0 : wrap_next(ctr, ud);
        #1;
        chk("exp_val",   32'(exp_val),   32'(m_pred));
        chk("locked",    32'(locked),    32'(m_locked));
        chk("err",       32'(err),       32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_errs));
        chk("err_val",   32'(err_val),   32'(m_errval));
    endtask

    task automatic run_up_to(input int target);
        for (int i = 0; i < 2 * MOD && ctr != target; i++)
            cycle(0, 1, 0, 0);
        chk("reach_target", 32'(ctr), 32'(target));
    endtask

    initial begin
        // 1: long reset, then 40 up counts including the 31->0 wrap
        repeat (10) cycle(1, 1, 0, 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_expval", 32'(exp_val), 0);
        repeat (40) cycle(0, 1, 0, 0);
        chk("p1_locked", 32'(locked), 1);
        chk("p1_errcnt", 32'(err_count), 0);

        // 2: reverse through 0 -> 31 -> 30
        run_up_to(2);
        repeat (5) cycle(0, 0, 0, 0);
        chk("p2_ctr", 32'(ctr), 29);
        chk("p2_locked", 32'(locked), 1);
        chk("p2_errcnt", 32'(err_count), 0);

        // 3: single glitch of 7 where 12 is expected
        run_up_to(12);
        cycle(0, 1, 1, 7);
        chk("p3_err", 32'(err), 1);
        chk("p3_errval", 32'(err_val), 7);
        chk("p3_errcnt", 32'(err_count), 1);
        chk("p3_locked", 32'(locked), 0);
        repeat (8) cycle(0, 1, 0, 0);
`ifdef UDC_CHK_STICKY_EN
        chk("p3_fault_errcnt", 32'(err_count), 1);
        chk("p3_fault_locked", 32'(locked), 0);
`else
        chk("p3_relock", 32'(locked), 1);
`endif

        // 4: second glitch
        cycle(0, 1, 1, (ctr + 9) % MOD);
        repeat (3) cycle(0, 1, 0, 0);
`ifdef UDC_CHK_STICKY_EN
        chk("p4_sticky_errcnt", 32'(err_count), 1);
        chk("p4_sticky_errval", 32'(err_val), 7);
`endif

        // random direction with sparse glitches
        for (int i = 0; i < 100; i++)
            cycle(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), int'($urandom_range(0, MOD - 1)));

        // 5: one-cycle reset while count is 17 and locked
        repeat (2) cycle(1, 1, 0, 0);
        run_up_to(17);
        chk("p5_pre_locked", 32'(locked), 1);
        cycle(1, 1, 0, 0);
        chk("p5_locked", 32'(locked), 0);
        chk("p5_errcnt", 32'(err_count), 0);
        chk("p5_expval", 32'(exp_val), 0);
        chk("p5_errval", 32'(err_val), 0);
        repeat (10) cycle(0, 1, 0, 0);
        chk("p5_restart_errcnt", 32'(err_count), 0);

        // 6: 300 cycles of random cnt_in
        for (int i = 0; i < 300; i++)
            cycle(0, 1'($urandom_range(0, 1)), 1, int'($urandom_range(0, MOD - 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
